// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and default parameters for the data-memory responder.
//   state_t     : responder FSM states
//   ADDR_W      : default request address width
//   DATA_W      : default data word width
//   DEPTH       : default number of words in the store
//   WAIT_CYCLES : default wait states inserted before each access (0..15)
package dmem_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WAIT   = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } state_t;

   localparam int ADDR_W      = 16;
   localparam int DATA_W      = 16;
   localparam int DEPTH       = 1024;
   localparam int WAIT_CYCLES = 2;

endpackage

// File: rtl/dmem_array.sv
// dmem_array: single-port synchronous RAM with registered read data, no reset.
//   clk   in  : clock
//   en    in  : port enable (read when we=0, write when we=1)
//   we    in  : write enable
//   idx   in  : word index
//   wdata in  : write data
//   rdata out : registered read data; holds its value when no read is done
module dmem_array #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 1024,
   parameter int IDX_W  = 10
) (
   input  logic              clk,
   input  logic              en,
   input  logic              we,
   input  logic [IDX_W-1:0]  idx,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   // storage write and registered read on the single port
   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            mem[idx] <= wdata;
         end else begin
            rdata <= mem[idx];
         end
      end
   end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: CPU data-memory port responder with configurable wait states.
//   clk         in  : clock, all state updates on rising edge
//   rst         in  : synchronous active-high reset
//   dmem_en     in  : request strobe
//   dmem_write  in  : 1 = write, 0 = read; sampled with dmem_en
//   addr        in  : word address
//   wdata       in  : write data
//   rdata       out : last completed read data (0 after reset)
//   rdata_valid out : one-cycle pulse, read complete
//   wr_done     out : one-cycle pulse, write complete
//   err         out : one-cycle pulse, address out of range
//   stall       out : combinational pipeline hold
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int ADDR_W      = dmem_pkg::ADDR_W,
   parameter int DATA_W      = dmem_pkg::DATA_W,
   parameter int DEPTH       = dmem_pkg::DEPTH,
   parameter int WAIT_CYCLES = dmem_pkg::WAIT_CYCLES
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              dmem_en,
   input  logic              dmem_write,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata,
   output logic              rdata_valid,
   output logic              wr_done,
   output logic              err,
   output logic              stall
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   // one extra bit so DEPTH == 2**ADDR_W still compares correctly
   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

   state_t              state, state_next;
   logic [3:0]          wait_cnt, wait_cnt_next;
   logic                load;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic                write_q;
   logic                have_rd;
   logic                in_range;
   logic                ram_en;
   logic                ram_we;
   logic [DATA_W-1:0]   ram_rdata;

   assign in_range = ({1'b0, addr_q} < DEPTH_L);

   // the array port fires only in ACCESS; reset on that edge suppresses it
   assign ram_en = (state == ACCESS) && in_range && !rst;
   assign ram_we = ram_en && write_q;

   // the RAM output register has no reset, so mask it until a read completes
   assign rdata = have_rd ? ram_rdata : '0;

   assign stall = !rst && ((dmem_en && ((state == IDLE) || (state == RESP)))
                           || (state == WAIT) || (state == ACCESS));

   // next-state, wait counter and request-latch load decisions
   always_comb begin
      state_next    = state;
      wait_cnt_next = wait_cnt;
      load          = 1'b0;
      case (state)
         IDLE, RESP: begin
            if (dmem_en) begin
               load          = 1'b1;
               wait_cnt_next = 4'(WAIT_CYCLES);
               state_next    = (WAIT_CYCLES > 0) ? WAIT : ACCESS;
            end else begin
               state_next    = IDLE;
            end
         end
         WAIT: begin
            wait_cnt_next = wait_cnt - 4'd1;
            // <= guards against a zero count ever stranding the FSM here
            if (wait_cnt <= 4'd1) begin
               state_next = ACCESS;
            end else begin
               state_next = WAIT;
            end
         end
         ACCESS: begin
            state_next = RESP;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // state, counter, request latch and completion pulse registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         wait_cnt    <= 4'd0;
         addr_q      <= '0;
         wdata_q     <= '0;
         write_q     <= 1'b0;
         rdata_valid <= 1'b0;
         wr_done     <= 1'b0;
         err         <= 1'b0;
         have_rd     <= 1'b0;
      end else begin
         state    <= state_next;
         wait_cnt <= wait_cnt_next;
         if (load) begin
            addr_q  <= addr;
            wdata_q <= wdata;
            write_q <= dmem_write;
         end
         rdata_valid <= (state == ACCESS) && in_range && !write_q;
         wr_done     <= (state == ACCESS) && in_range && write_q;
         err         <= (state == ACCESS) && !in_range;
         if ((state == ACCESS) && in_range && !write_q) begin
            have_rd <= 1'b1;
         end
      end
   end

   dmem_array #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .IDX_W  (IDX_W)
   ) u_array (
      .clk   (clk),
      .en    (ram_en),
      .we    (ram_we),
      .idx   (addr_q[IDX_W-1:0]),
      .wdata (wdata_q),
      .rdata (ram_rdata)
   );

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: scoreboard bench for dmem_responder.
// Instance a uses WAIT_CYCLES=2, instance b uses WAIT_CYCLES=0.
module tb_dmem_responder;

   localparam logic [2:0] K_RD  = 3'b100;
   localparam logic [2:0] K_WR  = 3'b010;
   localparam logic [2:0] K_ERR = 3'b001;

   typedef struct {
      logic [2:0]  kind;
      int          cyc;
      logic [15:0] data;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_a, en_a, we_a, rv_a, wd_a, er_a, stall_a;
   logic [15:0] addr_a, wdata_a, rdata_a;
   logic        rst_b, en_b, we_b, rv_b, wd_b, er_b, stall_b;
   logic [15:0] addr_b, wdata_b, rdata_b;

   exp_t q_a[$];
   exp_t q_b[$];
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;

   always @(posedge clk) cyc <= cyc + 1;

   dmem_responder #(.ADDR_W(16), .DATA_W(16), .DEPTH(1024), .WAIT_CYCLES(2)) u_a (
      .clk(clk), .rst(rst_a), .dmem_en(en_a), .dmem_write(we_a), .addr(addr_a),
      .wdata(wdata_a), .rdata(rdata_a), .rdata_valid(rv_a), .wr_done(wd_a),
      .err(er_a), .stall(stall_a));

   dmem_responder #(.ADDR_W(16), .DATA_W(16), .DEPTH(1024), .WAIT_CYCLES(0)) u_b (
      .clk(clk), .rst(rst_b), .dmem_en(en_b), .dmem_write(we_b), .addr(addr_b),
      .wdata(wdata_b), .rdata(rdata_b), .rdata_valid(rv_b), .wr_done(wd_b),
      .err(er_b), .stall(stall_b));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at cyc %0d: got %h want %h", name, cyc, act, exp);
      end
   endtask

   task automatic mon(input int inst, input logic [2:0] k, input logic [15:0] rd);
      exp_t e;
      if ((inst == 0 && q_a.size() == 0) || (inst == 1 && q_b.size() == 0)) begin
         total++;
         bad++;
         $display("FAIL unexpected_pulse inst=%0d cyc %0d: got kind %b want none", inst, cyc, k);
      end else begin
         if (inst == 0) e = q_a.pop_front();
         else           e = q_b.pop_front();
         chk($sformatf("pulse_kind[%0d]", inst), {29'd0, k}, {29'd0, e.kind});
         chk($sformatf("pulse_cycle[%0d]", inst), cyc, e.cyc);
         chk($sformatf("rdata[%0d]", inst), {16'd0, rd}, {16'd0, e.data});
      end
   endtask

   // monitor: every completion pulse is matched against the scoreboard
   always @(negedge clk) begin
      if ({rv_a, wd_a, er_a} != 3'b000) mon(0, {rv_a, wd_a, er_a}, rdata_a);
      if ({rv_b, wd_b, er_b} != 3'b000) mon(1, {rv_b, wd_b, er_b}, rdata_b);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // present a request in the current cycle, record its expected pulse,
   // check stall through the busy cycles, and return in its RESP cycle
   task automatic issue(input int inst, input logic wr, input logic [15:0] a,
                        input logic [15:0] d, input logic [2:0] k, input logic [15:0] exp_rd);
      int   w;
      exp_t e;
      w = (inst == 0) ? 2 : 0;
      e.kind = k;
      e.cyc  = cyc + w + 2;
      e.data = exp_rd;
      if (inst == 0) begin
         en_a = 1'b1; we_a = wr; addr_a = a; wdata_a = d; q_a.push_back(e);
      end else begin
         en_b = 1'b1; we_b = wr; addr_b = a; wdata_b = d; q_b.push_back(e);
      end
      for (int i = 0; i < w + 2; i++) begin
         @(negedge clk);
         chk($sformatf("stall_busy[%0d]", inst), {31'd0, (inst == 0) ? stall_a : stall_b}, 32'd1);
         step();
      end
   endtask

   // drop the request in a RESP cycle; stall must then be low
   task automatic idle(input int inst);
      if (inst == 0) en_a = 1'b0;
      else           en_b = 1'b0;
      @(negedge clk);
      chk($sformatf("stall_resp_idle[%0d]", inst), {31'd0, (inst == 0) ? stall_a : stall_b}, 32'd0);
      step();
   endtask

   initial begin
      rst_a = 1'b1; en_a = 1'b1; we_a = 1'b1; addr_a = 16'd0; wdata_a = 16'd0;
      rst_b = 1'b1; en_b = 1'b1; we_b = 1'b1; addr_b = 16'd0; wdata_b = 16'd0;
      // requests held during reset must neither stall nor take effect
      repeat (3) begin
         @(negedge clk);
         chk("reset_a", {rdata_a, rv_a, wd_a, er_a, stall_a}, 32'd0);
         chk("reset_b", {rdata_b, rv_b, wd_b, er_b, stall_b}, 32'd0);
         step();
      end
      en_a = 1'b0; we_a = 1'b0; en_b = 1'b0; we_b = 1'b0;
      rst_a = 1'b0; rst_b = 1'b0;
      repeat (10) begin
         @(negedge clk);
         chk("idle_a", {rdata_a, rv_a, wd_a, er_a, stall_a}, 32'd0);
         chk("idle_b", {rdata_b, rv_b, wd_b, er_b, stall_b}, 32'd0);
         step();
      end

      // WAIT_CYCLES=2: write then read the same address
      issue(0, 1'b1, 16'd5, 16'hBEEF, K_WR, 16'h0000);
      issue(0, 1'b0, 16'd5, 16'h0000, K_RD, 16'hBEEF);
      idle(0);

      // seed addresses 0..3 and 7
      for (int i = 0; i < 4; i++) issue(0, 1'b1, 16'(i), 16'h1000 + 16'(i), K_WR, 16'hBEEF);
      issue(0, 1'b1, 16'd7, 16'h0707, K_WR, 16'hBEEF);
      idle(0);

      // out-of-range read and write: err only, rdata held
      issue(0, 1'b0, 16'd1024, 16'h0000, K_ERR, 16'hBEEF);
      issue(0, 1'b1, 16'hFFFF, 16'h5555, K_ERR, 16'hBEEF);
      for (int i = 0; i < 4; i++) issue(0, 1'b0, 16'(i), 16'h0000, K_RD, 16'h1000 + 16'(i));
      idle(0);

      // reset during the second WAIT cycle aborts the write
      en_a = 1'b1; we_a = 1'b1; addr_a = 16'd7; wdata_a = 16'h1234;
      step();
      step();
      rst_a = 1'b1; en_a = 1'b0;
      @(negedge clk);
      chk("stall_in_reset_wait", {31'd0, stall_a}, 32'd0);
      step();
      rst_a = 1'b0;
      @(negedge clk);
      chk("rdata_after_reset", {16'd0, rdata_a}, 32'd0);
      step();
      issue(0, 1'b0, 16'd7, 16'h0000, K_RD, 16'h0707);
      idle(0);

      // reset on the ACCESS edge also suppresses the write
      en_a = 1'b1; we_a = 1'b1; addr_a = 16'd7; wdata_a = 16'h9999;
      step();
      step();
      step();
      rst_a = 1'b1; en_a = 1'b0;
      @(negedge clk);
      chk("stall_in_reset_access", {31'd0, stall_a}, 32'd0);
      step();
      rst_a = 1'b0;
      step();
      issue(0, 1'b0, 16'd7, 16'h0000, K_RD, 16'h0707);
      idle(0);

      // dmem_write without dmem_en does nothing
      we_a = 1'b1; addr_a = 16'd5; wdata_a = 16'h0BAD;
      repeat (4) step();
      issue(0, 1'b0, 16'd5, 16'h0000, K_RD, 16'hBEEF);
      idle(0);

      // WAIT_CYCLES=0: back-to-back, each presented in the previous RESP
      issue(1, 1'b1, 16'd0, 16'd1, K_WR, 16'h0000);
      issue(1, 1'b1, 16'd1, 16'd2, K_WR, 16'h0000);
      issue(1, 1'b0, 16'd0, 16'd0, K_RD, 16'd1);
      issue(1, 1'b0, 16'd1, 16'd0, K_RD, 16'd2);
      idle(1);

      repeat (6) step();
      chk("missing_pulses_a", q_a.size(), 32'd0);
      chk("missing_pulses_b", q_b.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
